// File: rtl/jtdsp16_do_seq.sv
// DSP16 do/redo instruction-cache sequencer: captures a loop body while it is
// fetched from ROM and replays it with the PC frozen. Redo support: JTDSP16_DO_REDO_EN.
module jtdsp16_do_seq #(
  parameter int CW = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cen2,
  input  logic        do_start,
  input  logic [10:0] do_data,
  input  logic        ins_adv,
  input  logic [15:0] rom_dout,
  output logic        cache_sel,
  output logic [15:0] cache_dout,
  output logic        pc_hold,
  output logic        no_int,
  output logic        busy,
  output logic        fault
);

  localparam logic [1:0] IDLE   = 2'd0,
                         FILL   = 2'd1,
                         REPLAY = 2'd2;

  logic [1:0]    st;
  logic [3:0]    ni;
  logic [6:0]    rep;
  logic [CW-1:0] ptr;
  logic [15:0]   mem [0:(2**CW)-2];
`ifdef JTDSP16_DO_REDO_EN
  logic          valid;
`endif

  logic [3:0] dni;
  logic [6:0] dk;
  logic       last;

  assign dni  = do_data[10:7];
  assign dk   = do_data[6:0];
  assign last = ptr == CW'(ni - 4'd1);

  always_ff @(posedge clk) begin
    if (rst) begin
      st    <= IDLE;
      ni    <= '0;
      rep   <= '0;
      ptr   <= '0;
      fault <= 1'b0;
`ifdef JTDSP16_DO_REDO_EN
      valid <= 1'b0;
`endif
    end else if (cen2) begin
      fault <= 1'b0;
      case (st)
        IDLE: if (do_start) begin
          if (dni != 4'd0) begin
            ni  <= dni;
            rep <= (dk <= 7'd1) ? 7'd0 : dk - 7'd1;
            ptr <= '0;
            st  <= FILL;
`ifdef JTDSP16_DO_REDO_EN
            valid <= 1'b0;
`endif
          end else begin
`ifdef JTDSP16_DO_REDO_EN
            // redo reuses the cached block and ni, replaying it K times
            if (valid) begin
              rep <= (dk <= 7'd1) ? 7'd1 : dk;
              ptr <= '0;
              st  <= REPLAY;
            end else begin
              fault <= 1'b1;
            end
`else
            fault <= 1'b1;
`endif
          end
        end
        FILL: begin
          if (do_start) fault <= 1'b1;
          if (ins_adv) begin
            if (last) begin
              ptr <= '0;
              st  <= (rep != 7'd0) ? REPLAY : IDLE;
`ifdef JTDSP16_DO_REDO_EN
              valid <= 1'b1;
`endif
            end else begin
              ptr <= ptr + 1'b1;
            end
          end
        end
        REPLAY: begin
          if (do_start) fault <= 1'b1;
          if (ins_adv) begin
            if (last) begin
              ptr <= '0;
              rep <= rep - 7'd1;
              if (rep == 7'd1) st <= IDLE;
            end else begin
              ptr <= ptr + 1'b1;
            end
          end
        end
        default: st <= IDLE;
      endcase
    end
  end

  // cache is never reset; its content only matters while cache_sel is high
  always_ff @(posedge clk) begin
    if (cen2 && st == FILL && ins_adv) mem[ptr] <= rom_dout;
  end

  assign cache_dout = mem[ptr];
  assign cache_sel  = st == REPLAY;
  assign pc_hold    = st == REPLAY;
  assign no_int     = st != IDLE;
  assign busy       = st != IDLE;

endmodule

// File: tb/tb_jtdsp16_do_seq.sv
// Scoreboard bench for jtdsp16_do_seq: fill words queue up their expected replays.
module tb_jtdsp16_do_seq;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cen2 = 1'b0;
  logic        do_start = 1'b0;
  logic [10:0] do_data = '0;
  logic        ins_adv = 1'b0;
  logic [15:0] rom_dout = '0;
  logic        cache_sel, pc_hold, no_int, busy, fault;
  logic [15:0] cache_dout;

  int checks = 0;
  int failures = 0;
  logic [15:0] exp_q[$];

  jtdsp16_do_seq #(.CW(4)) dut (
    .clk(clk), .rst(rst), .cen2(cen2), .do_start(do_start), .do_data(do_data),
    .ins_adv(ins_adv), .rom_dout(rom_dout), .cache_sel(cache_sel),
    .cache_dout(cache_dout), .pc_hold(pc_hold), .no_int(no_int),
    .busy(busy), .fault(fault)
  );

  always #5 clk = ~clk;

  // one cen2 period = two clk cycles; outputs sampled 1 time unit after the edge
  task automatic cyc(input logic ds, input logic [10:0] dd, input logic adv,
                     input logic [15:0] rom);
    do_start = ds; do_data = dd; ins_adv = adv; rom_dout = rom; cen2 = 1'b1;
    @(posedge clk); #1;
    cen2 = 1'b0; do_start = 1'b0; ins_adv = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic replay_all(input string tag);
    logic [15:0] e;
    int guard = 0;
    while (exp_q.size() > 0 && guard < 64) begin
      e = exp_q.pop_front();
      checks++;
      if (cache_sel !== 1'b1 || pc_hold !== 1'b1 || cache_dout !== e) begin
        failures++;
        $display("FAIL %s replay word %0d: sel=%b hold=%b dout=%h, required sel=1 hold=1 dout=%h",
                 tag, guard, cache_sel, pc_hold, cache_dout, e);
      end
      cyc(1'b0, 11'd0, 1'b1, 16'hdead);
      guard++;
    end
    checks++;
    if (busy !== 1'b0 || pc_hold !== 1'b0 || cache_sel !== 1'b0 || no_int !== 1'b0) begin
      failures++;
      $display("FAIL %s end: busy=%b hold=%b sel=%b no_int=%b, required all 0",
               tag, busy, pc_hold, cache_sel, no_int);
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    checks++;
    if ({cache_sel, pc_hold, no_int, busy, fault} !== 5'b0) begin
      failures++;
      $display("FAIL reset outputs: sel/hold/no_int/busy/fault=%b, required 00000",
               {cache_sel, pc_hold, no_int, busy, fault});
    end
  endtask

  task automatic test_redo_after_reset;
    cyc(1'b1, 11'h003, 1'b0, 16'h0);
    checks++;
    if (fault !== 1'b1 || busy !== 1'b0) begin
      failures++;
      $display("FAIL redo_after_reset: fault=%b busy=%b, required fault=1 busy=0", fault, busy);
    end
    cyc(1'b0, 11'h000, 1'b0, 16'h0);
    checks++;
    if (fault !== 1'b0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL redo_after_reset pulse: fault=%b busy=%b, required 0 0", fault, busy);
    end
  endtask

  task automatic test_fill_replay;
    logic [15:0] w [3];
    w[0] = 16'haaaa; w[1] = 16'hbbbb; w[2] = 16'hcccc;
    cyc(1'b1, {4'd3, 7'd4}, 1'b0, 16'h0);
    checks++;
    if (busy !== 1'b1 || no_int !== 1'b1 || cache_sel !== 1'b0 || pc_hold !== 1'b0) begin
      failures++;
      $display("FAIL fill entry: busy=%b no_int=%b sel=%b hold=%b, required 1 1 0 0",
               busy, no_int, cache_sel, pc_hold);
    end
    for (int i = 0; i < 3; i++) cyc(1'b0, 11'd0, 1'b1, w[i]);
    for (int r = 0; r < 3; r++) for (int i = 0; i < 3; i++) exp_q.push_back(w[i]);
    replay_all("fill_replay");
  endtask

  task automatic test_redo;
`ifdef JTDSP16_DO_REDO_EN
    cyc(1'b1, 11'h003, 1'b0, 16'h0);
    for (int r = 0; r < 3; r++) begin
      exp_q.push_back(16'haaaa); exp_q.push_back(16'hbbbb); exp_q.push_back(16'hcccc);
    end
    replay_all("redo");
`else
    cyc(1'b1, 11'h003, 1'b0, 16'h0);
    checks++;
    if (fault !== 1'b1 || busy !== 1'b0) begin
      failures++;
      $display("FAIL redo disabled: fault=%b busy=%b, required fault=1 busy=0", fault, busy);
    end
    cyc(1'b0, 11'h000, 1'b0, 16'h0);
    checks++;
    if (fault !== 1'b0) begin
      failures++;
      $display("FAIL redo disabled pulse width: fault=%b, required 0", fault);
    end
`endif
  endtask

  task automatic test_no_replay;
    cyc(1'b1, {4'd2, 7'd1}, 1'b0, 16'h0);
    for (int i = 0; i < 2; i++) begin
      checks++;
      if (busy !== 1'b1 || cache_sel !== 1'b0) begin
        failures++;
        $display("FAIL no_replay fill %0d: busy=%b sel=%b, required 1 0", i, busy, cache_sel);
      end
      cyc(1'b0, 11'd0, 1'b1, 16'h1230 + 16'(i));
    end
    checks++;
    if (busy !== 1'b0 || cache_sel !== 1'b0 || pc_hold !== 1'b0) begin
      failures++;
      $display("FAIL no_replay end: busy=%b sel=%b hold=%b, required 0 0 0", busy, cache_sel, pc_hold);
    end
  endtask

  task automatic test_stall_and_busy_do;
    logic [15:0] w [3];
    logic [15:0] e;
    w[0] = 16'hd00d; w[1] = 16'he00e; w[2] = 16'hf00f;
    cyc(1'b1, {4'd3, 7'd2}, 1'b0, 16'h0);
    cyc(1'b0, 11'd0, 1'b1, w[0]);
    cyc(1'b1, {4'd2, 7'd5}, 1'b0, 16'h0);
    checks++;
    if (fault !== 1'b1 || busy !== 1'b1 || cache_sel !== 1'b0) begin
      failures++;
      $display("FAIL do while busy: fault=%b busy=%b sel=%b, required 1 1 0", fault, busy, cache_sel);
    end
    cyc(1'b0, 11'd0, 1'b1, w[1]);
    checks++;
    if (fault !== 1'b0) begin
      failures++;
      $display("FAIL do while busy pulse width: fault=%b, required 0", fault);
    end
    cyc(1'b0, 11'd0, 1'b1, w[2]);
    for (int i = 0; i < 3; i++) exp_q.push_back(w[i]);
    for (int i = 0; i < 2; i++) begin
      e = exp_q.pop_front();
      checks++;
      if (cache_sel !== 1'b1 || cache_dout !== e) begin
        failures++;
        $display("FAIL stall pre word %0d: sel=%b dout=%h, required sel=1 dout=%h",
                 i, cache_sel, cache_dout, e);
      end
      cyc(1'b0, 11'd0, 1'b1, 16'h0);
    end
    for (int i = 0; i < 2; i++) begin
      cyc(1'b0, 11'd0, 1'b0, 16'h0);
      checks++;
      if (cache_sel !== 1'b1 || pc_hold !== 1'b1 || cache_dout !== exp_q[0]) begin
        failures++;
        $display("FAIL stall hold %0d: sel=%b hold=%b dout=%h, required 1 1 %h",
                 i, cache_sel, pc_hold, cache_dout, exp_q[0]);
      end
    end
    replay_all("stall");
  endtask

  task automatic test_reset_mid_replay;
    cyc(1'b1, {4'd2, 7'd3}, 1'b0, 16'h0);
    cyc(1'b0, 11'd0, 1'b1, 16'h5555);
    cyc(1'b0, 11'd0, 1'b1, 16'h6666);
    checks++;
    if (cache_sel !== 1'b1 || cache_dout !== 16'h5555) begin
      failures++;
      $display("FAIL reset_mid pre: sel=%b dout=%h, required 1 5555", cache_sel, cache_dout);
    end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    checks++;
    if (busy !== 1'b0 || cache_sel !== 1'b0 || no_int !== 1'b0 || pc_hold !== 1'b0) begin
      failures++;
      $display("FAIL reset_mid: busy=%b sel=%b no_int=%b hold=%b, required 0 0 0 0",
               busy, cache_sel, no_int, pc_hold);
    end
    cyc(1'b1, 11'h003, 1'b0, 16'h0);
    checks++;
    if (fault !== 1'b1 || busy !== 1'b0) begin
      failures++;
      $display("FAIL redo after reset_mid: fault=%b busy=%b, required 1 0", fault, busy);
    end
  endtask

  initial begin
    test_reset;
    test_redo_after_reset;
    test_fill_replay;
    test_redo;
    test_no_replay;
    test_stall_and_busy_do;
    test_reset_mid_replay;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
